step_incrementer: RTL
=====================

# step_incrementer

Parametrised, handshaked incrementer/decrementer for the datapath. It adds or subtracts a per-transaction step to an input word, with wrap-around or saturating overflow handling. Results are buffered in a 2-entry output queue, so it sustains one operation per cycle under backpressure. It is the registered, flow-controlled successor of the combinational +1 incrementer, used wherever counters or address pointers cross pipeline stages.

## Interface
- SIZE, 32, data width in bits (>= 2)
- STEP_W, 8, step operand width in bits (1..SIZE), unsigned
- PCLK  input  1  clock, all state on rising edge
- PRESET  input  1  asynchronous, active-high reset
- in_valid  input  1  input transaction present
- in_ready  output  1  block can accept an input this cycle
- in_data  input  SIZE  operand
- in_step  input  STEP_W  unsigned step magnitude
- in_dec  input  1  0 = add step, 1 = subtract step
- in_sat  input  1  1 = saturate on overflow, 0 = wrap (see Configuration)
- out_valid  output  1  result available at queue head
- out_ready  input  1  consumer accepts head this cycle
- out_data  output  SIZE  result at queue head
- out_ovf  output  1  head result overflowed/underflowed (wrapped or clamped)
- ops_cnt  output  16  count of results delivered (out_valid & out_ready), wraps 0xFFFF -> 0

## Operation
- Accept: in_valid & in_ready at a rising edge. Result is computed combinationally and written into the output queue in the same edge.
- Deliver: out_valid & out_ready at a rising edge pops the head.
- Arithmetic is done at SIZE+1 bits. The step is zero-extended to SIZE.
  - Add: ovf = carry out of bit SIZE-1.
  - Subtract: ovf = borrow (in_step > in_data).
- Wrap mode: out_data = result mod 2^SIZE, out_ovf = ovf.
- Saturate mode: on ovf, out_data = all-ones (add) or 0 (subtract), out_ovf = 1. Without ovf, the result is identical to wrap mode.
- in_step = 0: out_data = in_data, out_ovf = 0, regardless of in_dec/in_sat.
- Output queue: 2 entries, FIFO order. Each entry holds {data, ovf}. Occupancy is 0..2.
- in_ready = (occupancy < 2) & ~PRESET.
- Simultaneous push and pop: at occupancy 1, occupancy stays 1 and the new entry goes behind the head. At occupancy 2, no push is possible.
- out_data and out_ovf are held stable while out_valid & ~out_ready.
- in_data/in_step/in_dec/in_sat are ignored when in_valid = 0.

## Timing
- Reset values: out_valid 0, out_data 0, out_ovf 0, ops_cnt 0, occupancy 0, in_ready 0 while PRESET is high.
- Reset asserted mid-operation: the queue is flushed immediately and asynchronously. Buffered results are discarded, and ops_cnt does not count them.
- in_ready is 1 in the first cycle after PRESET deasserts.
- Latency: input accepted at edge N into an empty queue gives out_valid = 1 from edge N to N+1, with that result.
- Throughput: 1 result/cycle with out_ready held high.
- With out_ready low: 2 accepts fill the queue, then in_ready = 0 in the next cycle. in_ready returns to 1 in the cycle after the first pop.
- ops_cnt increments at the same edge as the pop.

## Configuration
- Macro STEP_INCREMENTER_SATURATE_EN.
- Defined: in_sat selects saturating behaviour per transaction as described in Operation.
- Undefined: the saturation logic is not built. in_sat is ignored (treated as 0), and every overflow wraps with out_ovf = 1. Port list is unchanged.

## Test plan
- Reset then a single add, SIZE=32: in_data 0x0000_0010, step 1, dec 0 -> one cycle later out_data 0x0000_0011, out_ovf 0, ops_cnt 1 after the pop.
- Wrap: in_data 0xFFFF_FFFE, step 5, add, sat 0 -> out_data 0x0000_0003, out_ovf 1. Subtract: 0x2 - 3 -> 0xFFFF_FFFF, ovf 1.
- Saturate (macro defined): 0xFFFF_FFF0 + 0xFF with sat 1 -> 0xFFFF_FFFF, ovf 1; 0x5 - 9 with sat 1 -> 0x0, ovf 1. Macro undefined: same stimulus wraps to 0x0000_00EF and 0xFFFF_FFFC.
- Backpressure: out_ready 0, offer 3 back-to-back inputs -> only 2 accepted, in_ready low. Raise out_ready -> results pop in order, 1/cycle, third input accepted the cycle after the first pop.
- Streaming: 70000 consecutive transactions with both handshakes high -> one result per cycle, no bubbles, ops_cnt wraps to 70000 mod 65536 = 4464.
- Reset mid-stream with 2 entries queued -> out_valid 0 immediately, ops_cnt 0, first post-reset input yields a correct result with no stale data.

Source files
------------

// File: rtl/step_incrementer.sv
// step_incrementer: adds or subtracts a per-transaction step, with wrap or saturate on overflow, into a 2-entry result queue.
// Optional saturation is built only when STEP_INCREMENTER_SATURATE_EN is defined; otherwise every overflow wraps.
module step_incrementer #(
  parameter int unsigned SIZE   = 32,
  parameter int unsigned STEP_W = 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   in_data,
  input  logic [STEP_W-1:0] in_step,
  input  logic              in_dec,
  input  logic              in_sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIZE-1:0]   out_data,
  output logic              out_ovf,
  output logic [15:0]       ops_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned EXT_W = SIZE + 1;

  typedef struct packed {
    logic [SIZE-1:0] data;
    logic            ovf;
  } entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  occ_t   occ_q, occ_d;
  entry_t head_q, tail_q;
  entry_t new_entry;
  logic   full_q;
  logic   push, pop;
  logic   load_head, load_tail, head_from_tail;

  logic [SIZE-1:0]  step_ext;
  logic [EXT_W-1:0] sum_ext, diff_ext;

  // Arithmetic at SIZE+1 bits: the top bit is carry (add) or borrow (subtract).
  assign step_ext = SIZE'(in_step);
  assign sum_ext  = {1'b0, in_data} + {1'b0, step_ext};
  assign diff_ext = {1'b0, in_data} - {1'b0, step_ext};

`ifndef STEP_INCREMENTER_SATURATE_EN
  logic unused_sat;
  assign unused_sat = in_sat;
`endif

  always_comb begin
    new_entry.ovf  = in_dec ? diff_ext[SIZE] : sum_ext[SIZE];
    new_entry.data = in_dec ? diff_ext[SIZE-1:0] : sum_ext[SIZE-1:0];
`ifdef STEP_INCREMENTER_SATURATE_EN
    if (in_sat && new_entry.ovf) begin
      new_entry.data = in_dec ? '0 : '1;
    end
`endif
  end

  assign in_ready = ~full_q & ~PRESET;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign out_data = head_q.data;
  assign out_ovf  = head_q.ovf;

  // Occupancy state: decides where a pushed result lands and when the tail moves up.
  always_comb begin
    occ_d          = occ_q;
    load_head      = 1'b0;
    load_tail      = 1'b0;
    head_from_tail = 1'b0;
    case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          load_head = 1'b1;
          occ_d     = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          load_head = 1'b1;
        end else if (push) begin
          load_tail = 1'b1;
          occ_d     = OCC_FULL;
        end else if (pop) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          head_from_tail = 1'b1;
          occ_d          = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      occ_q     <= OCC_EMPTY;
      out_valid <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      out_valid <= (occ_d != OCC_EMPTY);
      full_q    <= (occ_d == OCC_FULL);
    end
  end

  // Queue storage; the head is what the consumer sees and only moves on load or pop.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head) begin
        head_q <= new_entry;
      end else if (head_from_tail) begin
        head_q <= tail_q;
      end
      if (load_tail) begin
        tail_q <= new_entry;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ops_cnt <= '0;
    end else if (pop) begin
      ops_cnt <= ops_cnt + CNT_W'(1);
    end
  end

endmodule
